// File: rtl/kgp_ctrl_pkg.sv
// kgp_ctrl_pkg: shared definitions for the KGP-RISC multi-cycle controller.
//   - 3-bit state encoding (localparams plus the enum built on them)
//   - decoder op_class codes
//   - default memory-wait timeout
//   - helper that flags the two unused op_class codes
package kgp_ctrl_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;
    localparam logic [2:0] ST_ERROR  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXEC   = ST_EXEC,
        S_MEM    = ST_MEM,
        S_WB     = ST_WB,
        S_HALT   = ST_HALT,
        S_ERROR  = ST_ERROR
    } state_e;

    localparam logic [2:0] OP_ALU    = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_STORE  = 3'd2;
    localparam logic [2:0] OP_BRANCH = 3'd3;
    localparam logic [2:0] OP_HALT   = 3'd4;
    localparam logic [2:0] OP_NOP    = 3'd5;

    localparam int TIMEOUT_DEFAULT = 15;

    // Codes 6 and 7 are the only ones with both upper bits set.
    function automatic logic is_illegal_op(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// wait_timer: CW-bit memory wait counter.
//   clk, rst   : clock, asynchronous active-low reset
//   clear      : force the count to zero (priority over count)
//   count      : increment by one this cycle
//   limit      : number of counted cycles that constitutes a timeout
//   expired    : current count equals limit-1, so one more miss is fatal
module wait_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          count,
    input  logic [CW-1:0] limit,
    output logic          expired
);

    logic [CW-1:0] wait_cnt_q;
    logic [CW-1:0] wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clear) begin
            wait_cnt_d = '0;
        end else if (count) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign expired = (wait_cnt_q == limit - 1'b1);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/exec/mem/writeback sequencer for KGP-RISC.
//   clk, rst          : clock, asynchronous active-low reset
//   start             : leave IDLE (sampled only in IDLE)
//   op_class[2:0]     : decoder class (sampled only in DECODE)
//   mem_ready         : completion of the current memory request
//   mem_rd, mem_wr    : shared memory port requests
//   mem_sel           : 0 = PC address, 1 = data address
//   ir_we, pc_we, flag_we, reg_we : state-register write enables
//   busy, halted, err : status
// Outputs are decoded combinationally from state, op_q and mem_ready, so an
// asynchronous reset removes every request and enable immediately.
module multicycle_ctrl
    import kgp_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CW      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] op_class,
    input  logic       mem_ready,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       mem_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic       flag_we,
    output logic       reg_we,
    output logic       busy,
    output logic       halted,
    output logic       err
);

    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    state_e     state_q;
    logic [2:0] op_q;
    logic       miss;
    logic       expired;

    // A miss is a request cycle without ready. Every other cycle clears the
    // counter, so it is always zero on entry into FETCH or MEM.
    assign miss = (mem_rd | mem_wr) & ~mem_ready;

    wait_timer #(.CW(CW)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (~miss),
        .count   (miss),
        .limit   (LIMIT),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_ALU;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    // Ready is checked first so it wins over the timeout.
                    if (mem_ready)    state_q <= S_DECODE;
                    else if (expired) state_q <= S_ERROR;
                end
                S_DECODE: begin
                    op_q <= op_class;
                    if (op_class == OP_HALT)          state_q <= S_HALT;
                    else if (is_illegal_op(op_class)) state_q <= S_ERROR;
                    else                              state_q <= S_EXEC;
                end
                S_EXEC: begin
                    case (op_q)
                        OP_ALU:              state_q <= S_WB;
                        OP_LOAD, OP_STORE:   state_q <= S_MEM;
                        OP_BRANCH, OP_NOP:   state_q <= S_FETCH;
                        default:             state_q <= S_ERROR;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready)    state_q <= (op_q == OP_STORE) ? S_FETCH : S_WB;
                    else if (expired) state_q <= S_ERROR;
                end
                S_WB:    state_q <= S_FETCH;
                S_HALT:  state_q <= S_HALT;
                S_ERROR: state_q <= S_ERROR;
                default: state_q <= S_ERROR;
            endcase
        end
    end

    always_comb begin
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        mem_sel = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        flag_we = 1'b0;
        reg_we  = 1'b0;
        busy    = 1'b0;
        halted  = 1'b0;
        err     = 1'b0;
        case (state_q)
            S_FETCH: begin
                busy   = 1'b1;
                mem_rd = 1'b1;
                ir_we  = mem_ready;
            end
            S_DECODE: busy = 1'b1;
            S_EXEC: begin
                busy    = 1'b1;
                flag_we = (op_q == OP_ALU);
                pc_we   = (op_q == OP_BRANCH) || (op_q == OP_NOP);
            end
            S_MEM: begin
                busy    = 1'b1;
                mem_sel = 1'b1;
                mem_rd  = (op_q == OP_LOAD);
                mem_wr  = (op_q == OP_STORE);
                // A store retires on its data handshake; there is no WB.
                pc_we   = (op_q == OP_STORE) & mem_ready;
            end
            S_WB: begin
                busy   = 1'b1;
                reg_we = 1'b1;
                pc_we  = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            S_ERROR: err    = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl (TIMEOUT=4): directed scenarios with literal
// expectations, then randomized traffic checked each cycle against a
// table-driven instruction model.
module tb_multicycle_ctrl;

    localparam int TO = 4;

    logic       clk, rst, start, mem_ready;
    logic [2:0] op_class;
    logic       mem_rd, mem_wr, mem_sel, ir_we, pc_we, flag_we, reg_we, busy, halted, err;
    logic [9:0] dut_vec;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl #(.TIMEOUT(TO), .CW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op_class(op_class), .mem_ready(mem_ready),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_sel(mem_sel), .ir_we(ir_we), .pc_we(pc_we),
        .flag_we(flag_we), .reg_we(reg_we), .busy(busy), .halted(halted), .err(err)
    );

    assign dut_vec = {mem_rd, mem_wr, mem_sel, ir_we, pc_we, flag_we, reg_we, busy, halted, err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vectors: {rd, wr, sel, ir_we, pc_we, flag_we, reg_we, busy, halted, err}
    localparam logic [9:0] V_ZERO       = 10'b0000000000;
    localparam logic [9:0] V_FETCH_RDY  = 10'b1001000100;
    localparam logic [9:0] V_FETCH_WAIT = 10'b1000000100;
    localparam logic [9:0] V_BUSY       = 10'b0000000100;
    localparam logic [9:0] V_ALU_EX     = 10'b0000010100;
    localparam logic [9:0] V_WB         = 10'b0000101100;
    localparam logic [9:0] V_LD_MEM     = 10'b1010000100;
    localparam logic [9:0] V_ST_WAIT    = 10'b0110000100;
    localparam logic [9:0] V_ST_DONE    = 10'b0110100100;
    localparam logic [9:0] V_PC_EX      = 10'b0000100100;
    localparam logic [9:0] V_HALT       = 10'b0000000010;
    localparam logic [9:0] V_ERR        = 10'b0000000001;

    // ---------------- reference model ----------------
    // An instruction is a list of steps; a running machine works through the
    // list and a fresh fetch is appended whenever the list runs dry.
    typedef struct packed {
        logic rd, wr, sel, ir_on_rdy, pc_on_rdy, pc_now, flag_we, reg_we, is_decode;
    } step_t;

    localparam step_t STEP_FETCH  = 9'b100100000;
    localparam step_t STEP_DECODE = 9'b000000001;
    localparam step_t STEP_EXEC   = 9'b000000000;
    localparam step_t STEP_EX_ALU = 9'b000000100;
    localparam step_t STEP_EX_PC  = 9'b000001000;
    localparam step_t STEP_MEM_LD = 9'b101000000;
    localparam step_t STEP_MEM_ST = 9'b011010000;
    localparam step_t STEP_WB     = 9'b000001010;

    int    m_mode;    // 0 idle, 1 running, 2 halted, 3 error
    step_t m_q[$];
    int    m_misses;

    function automatic logic [9:0] model_out(input logic rdy);
        step_t s;
        if (m_mode == 2) return V_HALT;
        if (m_mode == 3) return V_ERR;
        if (m_mode != 1 || m_q.size() == 0) return V_ZERO;
        s = m_q[0];
        return {s.rd, s.wr, s.sel, s.ir_on_rdy & rdy, s.pc_now | (s.pc_on_rdy & rdy),
                s.flag_we, s.reg_we, 1'b1, 1'b0, 1'b0};
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_q.delete();
        m_misses = 0;
    endtask

    task automatic model_step(input logic st, input logic [2:0] op, input logic rdy);
        step_t s;
        if (m_mode == 0) begin
            if (st) begin
                m_mode = 1;
                m_q.delete();
                m_q.push_back(STEP_FETCH);
                m_misses = 0;
            end
        end else if (m_mode == 1) begin
            s = m_q[0];
            if (s.rd | s.wr) begin
                if (rdy) begin
                    void'(m_q.pop_front());
                    m_misses = 0;
                    if (s.ir_on_rdy) m_q.push_back(STEP_DECODE);
                end else begin
                    m_misses++;
                    if (m_misses == TO) begin
                        m_mode = 3;
                        m_q.delete();
                    end
                end
            end else begin
                void'(m_q.pop_front());
                if (s.is_decode) begin
                    case (op)
                        3'd0: begin m_q.push_back(STEP_EX_ALU); m_q.push_back(STEP_WB); end
                        3'd1: begin m_q.push_back(STEP_EXEC); m_q.push_back(STEP_MEM_LD); m_q.push_back(STEP_WB); end
                        3'd2: begin m_q.push_back(STEP_EXEC); m_q.push_back(STEP_MEM_ST); end
                        3'd3, 3'd5: m_q.push_back(STEP_EX_PC);
                        3'd4: begin m_mode = 2; m_q.delete(); end
                        default: begin m_mode = 3; m_q.delete(); end
                    endcase
                end
            end
            if (m_mode == 1 && m_q.size() == 0) m_q.push_back(STEP_FETCH);
        end
    endtask

    // Compare process: inputs are stable across the falling edge, so the
    // model is checked and then advanced with what the next rising edge sees.
    always @(negedge clk) begin
        logic [9:0] exp_v;
        if (!rst) model_reset();
        exp_v = model_out(mem_ready);
        checks++;
        if (dut_vec !== exp_v) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t got=%b want=%b", $time, dut_vec, exp_v);
        end
        if (rst) model_step(start, op_class, mem_ready);
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic r, input logic s, input logic [2:0] op, input logic rdy);
        @(posedge clk);
        #2;
        rst = r; start = s; op_class = op; mem_ready = rdy;
        @(negedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [9:0] want);
        checks++;
        if (dut_vec !== want) begin
            errors++;
            $display("FAIL %s got=%b want=%b", name, dut_vec, want);
        end
    endtask

    initial begin
        int v;
        logic [2:0] rop;
        rst = 1'b0; start = 1'b0; op_class = 3'd0; mem_ready = 1'b0;
        model_reset();

        // Reset held with start high, then release.
        repeat (3) begin cyc(0, 1, 0, 1); lit("reset_hold", V_ZERO); end
        cyc(1, 1, 0, 1); lit("idle_start", V_ZERO);
        // ALU zero wait (op_class wiggled after decode)
        cyc(1, 0, 0, 1); lit("alu_fetch", V_FETCH_RDY);
        cyc(1, 0, 0, 1); lit("alu_decode", V_BUSY);
        cyc(1, 0, 6, 1); lit("alu_exec", V_ALU_EX);
        cyc(1, 0, 7, 1); lit("alu_wb", V_WB);
        // LOAD with two data wait cycles; start ignored while busy
        cyc(1, 1, 1, 1); lit("ld_fetch", V_FETCH_RDY);
        cyc(1, 0, 1, 1); lit("ld_decode", V_BUSY);
        cyc(1, 0, 0, 1); lit("ld_exec", V_BUSY);
        cyc(1, 0, 0, 0); lit("ld_mem_w1", V_LD_MEM);
        cyc(1, 0, 0, 0); lit("ld_mem_w2", V_LD_MEM);
        cyc(1, 0, 0, 1); lit("ld_mem_done", V_LD_MEM);
        cyc(1, 0, 0, 1); lit("ld_wb", V_WB);
        // STORE under the same stimulus
        cyc(1, 0, 0, 1); lit("st_fetch", V_FETCH_RDY);
        cyc(1, 0, 2, 1); lit("st_decode", V_BUSY);
        cyc(1, 0, 0, 1); lit("st_exec", V_BUSY);
        cyc(1, 0, 0, 0); lit("st_mem_w1", V_ST_WAIT);
        cyc(1, 0, 0, 0); lit("st_mem_w2", V_ST_WAIT);
        cyc(1, 0, 0, 1); lit("st_mem_done", V_ST_DONE);
        // Fetch timeout: exactly four request cycles, then sticky error
        repeat (4) begin cyc(1, 0, 0, 0); lit("to_fetch_wait", V_FETCH_WAIT); end
        repeat (3) begin cyc(1, 1, 0, 1); lit("to_err_sticky", V_ERR); end
        // Ready on the fourth request cycle wins
        cyc(0, 0, 0, 0); lit("rst2", V_ZERO);
        cyc(1, 1, 0, 0); lit("idle2", V_ZERO);
        repeat (3) begin cyc(1, 0, 0, 0); lit("late_fetch_wait", V_FETCH_WAIT); end
        cyc(1, 0, 0, 1); lit("late_fetch_rdy", V_FETCH_RDY);
        cyc(1, 0, 5, 0); lit("nop_decode", V_BUSY);
        cyc(1, 0, 0, 0); lit("nop_exec", V_PC_EX);
        cyc(1, 0, 0, 1); lit("nop_next_fetch", V_FETCH_RDY);
        // HALT decode
        cyc(1, 0, 4, 0); lit("halt_decode", V_BUSY);
        repeat (3) begin cyc(1, 1, 0, 1); lit("halt_sticky", V_HALT); end
        // Illegal decode
        cyc(0, 0, 0, 1); lit("rst3", V_ZERO);
        cyc(1, 1, 0, 1); lit("idle3", V_ZERO);
        cyc(1, 0, 0, 1); lit("ill_fetch", V_FETCH_RDY);
        cyc(1, 0, 7, 1); lit("ill_decode", V_BUSY);
        repeat (3) begin cyc(1, 1, 0, 1); lit("ill_err_sticky", V_ERR); end
        // Asynchronous reset during a LOAD data wait
        cyc(0, 0, 0, 1); lit("rst4", V_ZERO);
        cyc(1, 1, 1, 1); lit("idle4", V_ZERO);
        cyc(1, 0, 1, 1); lit("rm_fetch", V_FETCH_RDY);
        cyc(1, 0, 1, 1); lit("rm_decode", V_BUSY);
        cyc(1, 0, 0, 0); lit("rm_exec", V_BUSY);
        cyc(1, 0, 0, 0); lit("rm_mem_wait", V_LD_MEM);
        #1 rst = 1'b0;
        #1 lit("rm_async_drop", V_ZERO);
        cyc(0, 0, 0, 1); lit("rm_hold", V_ZERO);
        cyc(1, 0, 0, 1); lit("rm_release_idle", V_ZERO);
        cyc(1, 0, 0, 1); lit("rm_stays_idle", V_ZERO);

        // Randomized traffic against the model
        repeat (2500) begin
            v = $urandom_range(0, 19);
            if (v < 15) begin
                case (v % 5)
                    0: rop = 3'd0;
                    1: rop = 3'd1;
                    2: rop = 3'd2;
                    3: rop = 3'd3;
                    default: rop = 3'd5;
                endcase
            end else if (v < 17) begin
                rop = 3'd4;
            end else begin
                rop = 3'($urandom_range(6, 7));
            end
            cyc(($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1,
                ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                rop,
                ($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencing controller for the KGP-RISC datapath. It steps each instruction through fetch, decode, execute, memory and writeback. It also generates the write enables for the DFF-based state registers: IR, PC, flags and register file. A single memory port is shared between instruction fetch and data access, and `multicycle_ctrl` arbitrates that port by phase and guards every memory wait with a timeout.

## Interface
- `TIMEOUT`, default 15: maximum consecutive request cycles without `mem_ready` before the controller faults; legal range 1..2^CW-1.
- `CW`, default 4: width of the wait counter.

- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: begin execution; sampled only in IDLE.
- `op_class` in 3: decoder class, sampled only in DECODE.
  - 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 HALT, 5 NOP, 6-7 illegal.
- `mem_ready` in 1: memory completion, meaningful only while `mem_rd` or `mem_wr` is high.
- `mem_rd` out 1: memory read request.
- `mem_wr` out 1: memory write request.
- `mem_sel` out 1: 0 selects the instruction address (PC), 1 selects the data address.
- `ir_we` out 1: instruction register load.
- `pc_we` out 1: PC update, exactly one pulse per completed instruction.
- `flag_we` out 1: flag DFFs load.
- `reg_we` out 1: register file write.
- `busy` out 1: high in FETCH, DECODE, EXEC, MEM and WB.
- `halted` out 1: high in HALT.
- `err` out 1: high in ERROR.

## Operation
States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR.

Registered state is `state`, `op_q` (3 bits) and `wait_cnt` (CW bits). All outputs are combinational from `state`, `op_q` and `mem_ready`.

- **IDLE**
  - All outputs 0.
  - `start`=1 -> FETCH.
- **FETCH**
  - `mem_rd`=1, `mem_sel`=0.
  - On `mem_ready`: `ir_we`=1, -> DECODE.
- **DECODE** (one cycle)
  - `op_q` <= `op_class`.
  - HALT -> HALT; 6 or 7 -> ERROR; otherwise -> EXEC.
- **EXEC** (one cycle, uses `op_q`)
  - ALU: `flag_we`=1, -> WB.
  - LOAD, STORE: -> MEM.
  - BRANCH, NOP: `pc_we`=1, -> FETCH.
- **MEM**
  - `mem_sel`=1.
  - LOAD: `mem_rd`=1; on `mem_ready` -> WB.
  - STORE: `mem_wr`=1; on `mem_ready`, `pc_we`=1, -> FETCH.
- **WB** (one cycle, ALU and LOAD only)
  - `reg_we`=1, `pc_we`=1, -> FETCH.
- **HALT**: absorbing; `halted`=1; exit only by reset.
- **ERROR**: absorbing; `err`=1; exit only by reset.

Wait counter:
- `wait_cnt` clears on every entry into FETCH or MEM.
- It increments on each request cycle in which `mem_ready`=0.
- A request cycle with `mem_ready`=0 and `wait_cnt`==TIMEOUT-1 -> ERROR.
- `mem_ready`=1 on that same cycle completes normally, so ready wins over timeout.

Boundary rules:
- `mem_ready` outside a request cycle is ignored.
- `start` outside IDLE is ignored.
- `mem_rd` and `mem_wr` are never high together.
- `op_class` changing after DECODE has no effect.
- Async reset mid-access (`rst` low) drops `mem_rd`/`mem_wr` and all enables immediately, with no completion pulse.

## Timing
Reset values: state IDLE, `op_q`=0, `wait_cnt`=0, and every output 0.

Latency, counted from the first FETCH cycle to the `pc_we` cycle inclusive, with zero-wait memory (`mem_ready` high on the first request cycle):

- ALU: 4 cycles (FETCH, DECODE, EXEC, WB).
- LOAD: 5 cycles.
- STORE: 4 cycles.
- BRANCH, NOP: 3 cycles.

Each memory wait cycle adds one cycle.

Handshake rules:
- A request holds stable until the cycle `mem_ready` is sampled high.
- `ir_we` is asserted in the same cycle as the fetch `mem_ready`.
- The next FETCH begins the cycle after `pc_we`.
- After `start`, FETCH is entered on the next edge.

## Structure
- Shared package `kgp_ctrl_pkg`:
  - state encoding localparams (3-bit);
  - `op_class` codes (OP_ALU … OP_NOP);
  - the default TIMEOUT value.
- Sub-module `wait_timer` (CW-bit counter) with inputs clear, count and limit, and output `expired`.
  - `wait_timer` uses the same `clk`/`rst`.
  - The FSM, `op_q` and the output decode stay in `multicycle_ctrl`.

## Test plan
All scenarios run with TIMEOUT=4.

- **Reset**: hold `rst`=0 three cycles with `start`=1 -> all outputs 0. Release `rst` -> FETCH one cycle after `start` is sampled.
- **ALU, zero wait**: `op_class`=0, `mem_ready` constant 1 -> `ir_we` cycle 1, `flag_we` cycle 3, `reg_we` and `pc_we` cycle 4, next `mem_rd` cycle 5.
- **LOAD, two wait cycles on data**: `mem_rd`/`mem_sel`=1 for 3 cycles, then WB `reg_we` and `pc_we` -> 7 cycles total.
  - STORE under the same stimulus: `mem_wr` is never coincident with `mem_rd`, and `pc_we` coincides with `mem_ready`.
- **Timeout**:
  - `mem_ready` held 0 in FETCH -> `mem_rd` high exactly 4 cycles, then `err`=1 sticky.
  - Repeat with `mem_ready`=1 on the 4th request cycle -> normal DECODE, no error.
- **Decode faults**: `op_class`=4 -> `halted`=1 after DECODE with `busy`=0. `op_class`=7 -> `err`=1. Neither state is left without reset.
- **Reset mid-MEM**: assert `rst`=0 during a LOAD wait -> `mem_rd` low asynchronously and no `reg_we`. Release -> IDLE.
